// File: rtl/clk_div_prog.sv
// ============================================================================
// Module   : clk_div_prog
// Purpose  : Programmable clock-enable divider: 50%-duty divided clock, tick
//            pulse and running tick count, ratio changes only at period edges.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_prog #(
    parameter int CNT_W       = 16,
    parameter int DIV_DEFAULT = 1024,
    parameter int TICK_W      = 8
) (
    input  logic              clk_1,
    input  logic              rst,
    input  logic              sc,
    input  logic              en,
    input  logic [CNT_W-1:0]  div_val,
    input  logic              div_load,
    output logic              clk_div,
    output logic              tick,
    output logic [TICK_W-1:0] tick_cnt,
    output logic [CNT_W-1:0]  div_cur,
    output logic              load_err
);

    localparam logic [CNT_W-1:0]  C_DIV_RST = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0]  C_DIV_MIN = CNT_W'(2);
    localparam logic [CNT_W-1:0]  C_ONE     = CNT_W'(1);
    localparam logic [TICK_W-1:0] C_TICK1   = TICK_W'(1);

    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_pend_val;
    logic              r_pend_vld;

    logic              w_load_ok;
    logic              w_load_bad;
    logic              w_wrap;
    logic [CNT_W-1:0]  w_div_adopt;

    logic [CNT_W-1:0]  w_cnt_n;
    logic [CNT_W-1:0]  w_div_n;
    logic [CNT_W-1:0]  w_pend_val_n;
    logic              w_pend_vld_n;
    logic [TICK_W-1:0] w_tick_cnt_n;
    logic              w_tick_n;

    assign w_load_ok  = div_load && (div_val >= C_DIV_MIN);
    assign w_load_bad = div_load && (div_val <  C_DIV_MIN);
    assign w_wrap     = en && (r_cnt == (div_cur - C_ONE));

    // A load arriving on the adopting cycle beats an older pending value.
    assign w_div_adopt = w_load_ok  ? div_val    :
                         r_pend_vld ? r_pend_val : div_cur;

    always_comb begin
        w_cnt_n      = r_cnt;
        w_div_n      = div_cur;
        w_pend_val_n = r_pend_val;
        w_pend_vld_n = r_pend_vld;
        w_tick_cnt_n = tick_cnt;
        w_tick_n     = 1'b0;

        if (sc) begin
            w_cnt_n      = '0;
            w_div_n      = w_div_adopt;
            w_pend_vld_n = 1'b0;
            w_tick_cnt_n = '0;
        end else if (w_wrap) begin
            w_cnt_n      = '0;
            w_div_n      = w_div_adopt;
            w_pend_vld_n = 1'b0;
            w_tick_cnt_n = tick_cnt + C_TICK1;
            w_tick_n     = 1'b1;
        end else begin
            if (en) begin
                w_cnt_n = r_cnt + C_ONE;
            end
            if (w_load_ok) begin
                w_pend_val_n = div_val;
                w_pend_vld_n = 1'b1;
            end
        end
    end

    // clk_div is derived from next-state count and divisor so it lines up
    // with the count value visible in the same cycle.
    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_pend_val <= '0;
            r_pend_vld <= 1'b0;
            div_cur    <= C_DIV_RST;
            clk_div    <= 1'b0;
            tick       <= 1'b0;
            tick_cnt   <= '0;
            load_err   <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_n;
            r_pend_val <= w_pend_val_n;
            r_pend_vld <= w_pend_vld_n;
            div_cur    <= w_div_n;
            clk_div    <= (w_cnt_n >= (w_div_n >> 1));
            tick       <= w_tick_n;
            tick_cnt   <= w_tick_cnt_n;
            load_err   <= w_load_bad;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_prog.sv
// ============================================================================
// Module   : tb_clk_div_prog
// Purpose  : Randomised self-checking bench for clk_div_prog against a
//            period/position reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_div_prog;

    localparam int CNT_W  = 16;
    localparam int TICK_W = 8;

    logic              clk_1    = 1'b0;
    logic              rst      = 1'b1;
    logic              sc       = 1'b0;
    logic              en       = 1'b0;
    logic [CNT_W-1:0]  div_val  = '0;
    logic              div_load = 1'b0;
    logic              clk_div;
    logic              tick;
    logic [TICK_W-1:0] tick_cnt;
    logic [CNT_W-1:0]  div_cur;
    logic              load_err;

    clk_div_prog #(.CNT_W(CNT_W), .DIV_DEFAULT(1024), .TICK_W(TICK_W)) dut (
        .clk_1    (clk_1),
        .rst      (rst),
        .sc       (sc),
        .en       (en),
        .div_val  (div_val),
        .div_load (div_load),
        .clk_div  (clk_div),
        .tick     (tick),
        .tick_cnt (tick_cnt),
        .div_cur  (div_cur),
        .load_err (load_err)
    );

    initial forever #5 clk_1 = ~clk_1;

    int    n_checks = 0;
    int    n_pass   = 0;
    string phase    = "reset";

    // Reference model: position within the current period, the ratio in
    // force, a pending ratio (-1 = none) and the completed-period count.
    int m_pos, m_n, m_pend, m_ticks;
    bit m_tick, m_err;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        m_pos = 0; m_n = 1024; m_pend = -1; m_ticks = 0; m_tick = 0; m_err = 0;
    endtask

    task automatic model_step(input bit s, input bit e, input bit l, input int v);
        bit ok;
        ok    = l && (v >= 2);
        m_err = l && (v < 2);
        m_tick = 0;
        if (s) begin
            m_pos = 0; m_ticks = 0;
            if (ok) m_n = v; else if (m_pend >= 0) m_n = m_pend;
            m_pend = -1;
        end else if (e && (m_pos == m_n - 1)) begin
            m_pos = 0; m_tick = 1;
            m_ticks = (m_ticks + 1) % (1 << TICK_W);
            if (ok) m_n = v; else if (m_pend >= 0) m_n = m_pend;
            m_pend = -1;
        end else begin
            if (e) m_pos++;
            if (ok) m_pend = v;
        end
    endtask

    task automatic check_outs();
        check_val({phase, ".clk_div"},  32'(clk_div),  32'(m_pos >= m_n / 2));
        check_val({phase, ".tick"},     32'(tick),     32'(m_tick));
        check_val({phase, ".tick_cnt"}, 32'(tick_cnt), 32'(m_ticks));
        check_val({phase, ".div_cur"},  32'(div_cur),  32'(m_n));
        check_val({phase, ".load_err"}, 32'(load_err), 32'(m_err));
    endtask

    // One clock: drive at the falling edge, step the model on the rising
    // edge, compare 1 time unit later.
    task automatic cyc(input bit s, input bit e, input bit l, input int v);
        sc = s; en = e; div_load = l; div_val = v[CNT_W-1:0];
        @(posedge clk_1);
        model_step(s, e, l, v);
        #1;
        check_outs();
        @(negedge clk_1);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk_1);
        check_outs();
        rst = 1'b0;

        phase = "default";
        repeat (3 * 1024) cyc(0, 1, 0, 0);
        check_val("default.three_ticks", 32'(tick_cnt), 32'd3);

        phase = "load5";
        repeat (300) cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 5);
        repeat (760) cyc(0, 1, 0, 0);
        check_val("load5.div_cur", 32'(div_cur), 32'd5);

        phase = "sc_pend";
        cyc(1, 1, 1, 1024);
        repeat (20) cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 10);
        repeat (99) cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        check_val("sc_pend.div_cur", 32'(div_cur), 32'd10);
        repeat (30) cyc(0, 1, 0, 0);

        phase = "bad_load";
        cyc(1, 1, 0, 0);
        cyc(0, 1, 1, 1);
        cyc(0, 1, 1, 0);
        cyc(0, 1, 1, 8);
        cyc(0, 1, 1, 6);
        repeat (20) cyc(0, 1, 0, 0);
        check_val("bad_load.div_cur", 32'(div_cur), 32'd6);

        phase = "en_pause";
        cyc(1, 1, 1, 4);
        for (int i = 0; i < 8 && m_pos != 3; i++) cyc(0, 1, 0, 0);
        repeat (7) cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        check_val("en_pause.tick", 32'(tick), 32'd1);
        repeat (20) cyc(0, 1, 0, 0);

        phase = "random";
        for (int i = 0; i < 3000; i++)
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 7) == 0), int'($urandom_range(0, 12)));

        phase = "tick_wrap";
        cyc(1, 1, 1, 2);
        repeat (520) cyc(0, 1, 0, 0);
        for (int i = 0; i < 4 && m_pos != 1; i++) cyc(0, 1, 0, 0);

        phase = "async_rst";
        rst = 1'b1;
        #1;
        model_reset();
        check_outs();
        @(negedge clk_1);
        rst = 1'b0;
        repeat (1030) cyc(0, 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
